// File: rtl/cam_pkg.sv
// Shared types and default geometry for the camera capture path.
package cam_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_SYNC,
      ST_CAPTURE
   } cam_state_t;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_ADDR_W   = 19;

   typedef logic [7:0]            pixel_t;
   typedef logic [DEF_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/cam_sync_edge.sv
// Registers one camera sync pin and reports its level plus rise/fall pulses,
// all one cycle behind the pin.
module cam_sync_edge (
   input  logic PCLK_cam,
   input  logic rst_n,
   input  logic sig,
   output logic level,
   output logic rise,
   output logic fall
);

   logic sig_q;
   logic sig_prev;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge PCLK_cam) begin
      if (!rst_n) begin
         sig_q    <= 1'b0;
         sig_prev <= 1'b0;
      end else begin
         sig_q    <= sig;
         sig_prev <= sig_q;
      end
   end

   assign level = sig_q;
   assign rise  = sig_q & ~sig_prev;
   assign fall  = ~sig_q & sig_prev;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer: arms on start, aligns to VSYNC, writes pixels to the frame buffer.
// Define CAM_CTRL_STATS_EN to build the frame_count / drop_count statistics counters.
module cam_capture_ctrl
   import cam_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
   input  logic              PCLK_cam,
   input  logic              rst_n,
   input  logic              start,
   input  logic              continuous,
   input  logic              abort,
   input  logic              VSYNC_cam,
   input  logic              HREF_cam,
   input  logic              pix_valid,
   input  logic [7:0]        pix_data,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_err,
   output logic [7:0]        frame_count,
   output logic [15:0]       drop_count
);

   localparam int unsigned PIX_W  = $clog2(H_ACTIVE + 1);
   localparam int unsigned LINE_W = $clog2(V_ACTIVE + 1);

   cam_state_t state, state_nxt;

   logic vs_level, vs_rise, vs_fall;
   logic href_level, href_rise, href_fall;
   logic unused_edges;

   logic [PIX_W-1:0]  pix_cnt;
   logic [LINE_W-1:0] line_cnt;
   logic [ADDR_W-1:0] line_base;
   logic [ADDR_W-1:0] addr_cnt;
   logic              geom_err;
   logic              ovr_err;

   logic capturing, accept, in_range, reg_free;
   logic load, ovr_drop, geo_drop, frame_end, frame_good;

   cam_sync_edge u_vsync_edge (
      .PCLK_cam (PCLK_cam),
      .rst_n    (rst_n),
      .sig      (VSYNC_cam),
      .level    (vs_level),
      .rise     (vs_rise),
      .fall     (vs_fall)
   );

   cam_sync_edge u_href_edge (
      .PCLK_cam (PCLK_cam),
      .rst_n    (rst_n),
      .sig      (HREF_cam),
      .level    (href_level),
      .rise     (href_rise),
      .fall     (href_fall)
   );

   assign unused_edges = ^{vs_fall, href_level, href_rise};

   always_ff @(posedge PCLK_cam) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: default assignment first so no path through this block can infer a latch.
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE:    if (start)     state_nxt = ST_ARM;
            ST_ARM:     if (vs_level)  state_nxt = ST_SYNC;
            ST_SYNC:    if (!vs_level) state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (vs_rise)   state_nxt = continuous ? ST_SYNC : ST_IDLE;
            default:                   state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state != ST_IDLE);
   end

   assign capturing  = (state == ST_CAPTURE);
   assign accept     = capturing && !abort && pix_valid && HREF_cam;
   assign in_range   = (pix_cnt < PIX_W'(H_ACTIVE)) && (line_cnt < LINE_W'(V_ACTIVE));
   assign reg_free   = !wr_valid || wr_ready;
   assign load       = accept && in_range && reg_free;
   assign ovr_drop   = accept && in_range && !reg_free;
   assign geo_drop   = accept && !in_range;
   assign frame_end  = capturing && !abort && vs_rise;
   assign frame_good = (line_cnt == LINE_W'(V_ACTIVE)) && !geom_err && !ovr_err;

   // Address advances for every in-range slot, written or not, so it always equals line*H_ACTIVE+pixel.
   always_ff @(posedge PCLK_cam) begin
      if (!rst_n) begin
         pix_cnt    <= '0;
         line_cnt   <= '0;
         line_base  <= '0;
         addr_cnt   <= '0;
         geom_err   <= 1'b0;
         ovr_err    <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= frame_end && frame_good;
         frame_err  <= frame_end && !frame_good;
         if (state == ST_SYNC) begin
            pix_cnt   <= '0;
            line_cnt  <= '0;
            line_base <= '0;
            addr_cnt  <= '0;
            geom_err  <= 1'b0;
            ovr_err   <= 1'b0;
         end else if (capturing) begin
            if (href_fall) begin
               if (pix_cnt != PIX_W'(H_ACTIVE))   geom_err <= 1'b1;
               if (line_cnt != LINE_W'(V_ACTIVE)) line_cnt <= line_cnt + 1'b1;
               pix_cnt   <= '0;
               line_base <= line_base + ADDR_W'(H_ACTIVE);
               addr_cnt  <= line_base + ADDR_W'(H_ACTIVE);
            end else if (accept) begin
               if (pix_cnt != PIX_W'(H_ACTIVE)) pix_cnt  <= pix_cnt + 1'b1;
               if (in_range)                    addr_cnt <= addr_cnt + 1'b1;
            end
            if (geo_drop) geom_err <= 1'b1;
            if (ovr_drop) ovr_err  <= 1'b1;
         end
      end
   end

   // Single output register; a held write is only released by wr_ready or abort.
   always_ff @(posedge PCLK_cam) begin
      if (!rst_n) begin
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else if (abort) begin
         wr_valid <= 1'b0;
      end else if (load) begin
         wr_valid <= 1'b1;
         wr_addr  <= addr_cnt;
         wr_data  <= pix_data;
      end else if (wr_ready) begin
         wr_valid <= 1'b0;
      end
   end

`ifdef CAM_CTRL_STATS_EN
   logic [7:0]  frame_cnt_q;
   logic [15:0] drop_cnt_q;

   always_ff @(posedge PCLK_cam) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (frame_done) frame_cnt_q <= frame_cnt_q + 1'b1;
         if ((ovr_drop || geo_drop) && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
   end

   assign frame_count = frame_cnt_q;
   assign drop_count  = drop_cnt_q;
`else
   assign frame_count = '0;
   assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Scoreboard bench for cam_capture_ctrl with a 4x3 frame geometry.
module tb_cam_capture_ctrl;

   localparam int H = 4;
   localparam int V = 3;
   localparam int AW = 19;
`ifdef CAM_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   logic          PCLK_cam = 1'b0;
   logic          rst_n;
   logic          start, continuous, abort;
   logic          VSYNC_cam, HREF_cam, pix_valid;
   logic [7:0]    pix_data;
   logic          wr_valid, wr_ready;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          busy, frame_done, frame_err;
   logic [7:0]    frame_count;
   logic [15:0]   drop_count;

   wr_t sb[$];
   int  errors = 0;
   int  checks = 0;
   int  done_cnt = 0;
   int  err_cnt = 0;

   always #5 PCLK_cam = ~PCLK_cam;

   cam_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
      .PCLK_cam    (PCLK_cam),
      .rst_n       (rst_n),
      .start       (start),
      .continuous  (continuous),
      .abort       (abort),
      .VSYNC_cam   (VSYNC_cam),
      .HREF_cam    (HREF_cam),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_err   (frame_err),
      .frame_count (frame_count),
      .drop_count  (drop_count)
   );

   task automatic tick();
      @(posedge PCLK_cam);
      #1;
   endtask

   // Pops the scoreboard on every handshake and tallies done/err pulses.
   task automatic monitor();
      wr_t exp;
      forever begin
         @(negedge PCLK_cam);
         if (rst_n === 1'b1 && wr_valid === 1'b1 && wr_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got addr=%0d data=%02h, expected no write", wr_addr, wr_data);
            end else begin
               exp = sb.pop_front();
               if (wr_addr !== exp.addr || wr_data !== exp.data) begin
                  errors++;
                  $display("FAIL write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                           wr_addr, wr_data, exp.addr, exp.data);
               end
            end
         end
         if (frame_done === 1'b1) done_cnt++;
         if (frame_err === 1'b1)  err_cnt++;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
      VSYNC_cam = 1'b1; HREF_cam = 1'b0; pix_valid = 1'b0; pix_data = 8'h00; wr_ready = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      done_cnt = 0;
      err_cnt  = 0;
      sb.delete();
   endtask

   task automatic arm();
      tick(); start = 1'b1;
      tick(); start = 1'b0;
      tick();
      tick();
   endtask

   task automatic begin_frame();
      tick(); VSYNC_cam = 1'b0;
      repeat (4) tick();
   endtask

   // ready_lo: cycles of the line with wr_ready low; drop: pixels expected to be lost.
   task automatic drive_line(input int lidx, input int npix, input logic [7:0] ready_lo,
                             input logic [7:0] drop, input bit exp_wr);
      wr_t w;
      for (int i = 0; i < npix; i++) begin
         tick();
         HREF_cam  = 1'b1;
         pix_valid = 1'b1;
         pix_data  = 8'(lidx * 16 + i + 1);
         wr_ready  = !ready_lo[i];
         if (exp_wr && !drop[i]) begin
            w.addr = AW'(lidx * H + i);
            w.data = 8'(lidx * 16 + i + 1);
            sb.push_back(w);
         end
      end
      tick(); HREF_cam = 1'b0; pix_valid = 1'b0; wr_ready = 1'b1;
      tick();
      tick();
   endtask

   task automatic full_frame();
      for (int l = 0; l < V; l++) drive_line(l, H, 8'h00, 8'h00, 1'b1);
   endtask

   // Pulse must be absent one cycle after the registered rise and present the cycle after.
   task automatic end_frame(input bit exp_done, input bit exp_err);
      tick(); VSYNC_cam = 1'b1;
      @(negedge PCLK_cam);
      @(negedge PCLK_cam);
      checks++;
      if (frame_done !== 1'b0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL pulse_early: got done=%b err=%b, expected 0 0", frame_done, frame_err);
      end
      @(negedge PCLK_cam);
      checks++;
      if (frame_done !== exp_done || frame_err !== exp_err) begin
         errors++;
         $display("FAIL pulse_timing: got done=%b err=%b, expected %b %b", frame_done, frame_err, exp_done, exp_err);
      end
      repeat (3) tick();
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge PCLK_cam);
      checks++;
      if ({wr_valid, busy, frame_done, frame_err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got valid/busy/done/err=%b, expected 0000", {wr_valid, busy, frame_done, frame_err});
      end
      checks++;
      if (wr_addr !== '0 || wr_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_wr: got addr=%0d data=%02h, expected 0 00", wr_addr, wr_data);
      end
      checks++;
      if (frame_count !== 8'd0 || drop_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_stats: got frames=%0d drops=%0d, expected 0 0", frame_count, drop_count);
      end
   endtask

   task automatic test_single_shot();
      do_reset();
      arm();
      begin_frame();
      full_frame();
      end_frame(1'b1, 1'b0);
      @(negedge PCLK_cam);
      checks++;
      if (sb.size() != 0 || done_cnt != 1 || err_cnt != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_shot: got pending=%0d done=%0d err=%0d busy=%b, expected 0 1 0 0",
                  sb.size(), done_cnt, err_cnt, busy);
      end
      checks++;
      if (frame_count !== 8'(STATS ? 1 : 0)) begin
         errors++;
         $display("FAIL single_shot_count: got %0d, expected %0d", frame_count, STATS ? 1 : 0);
      end
   endtask

   task automatic test_continuous();
      do_reset();
      continuous = 1'b1;
      arm();
      begin_frame();
      full_frame();
      end_frame(1'b1, 1'b0);
      @(negedge PCLK_cam);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL continuous_busy_gap: got busy=%b, expected 1", busy);
      end
      begin_frame();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL continuous_busy_frame2: got busy=%b, expected 1", busy);
      end
      full_frame();
      continuous = 1'b0;
      end_frame(1'b1, 1'b0);
      @(negedge PCLK_cam);
      checks++;
      if (sb.size() != 0 || done_cnt != 2 || err_cnt != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL continuous: got pending=%0d done=%0d err=%0d busy=%b, expected 0 2 0 0",
                  sb.size(), done_cnt, err_cnt, busy);
      end
      checks++;
      if (frame_count !== 8'(STATS ? 2 : 0)) begin
         errors++;
         $display("FAIL continuous_count: got %0d, expected %0d", frame_count, STATS ? 2 : 0);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      arm();
      begin_frame();
      drive_line(0, H, 8'h00, 8'h00, 1'b1);
      drive_line(1, H, 8'h07, 8'h06, 1'b1);
      drive_line(2, H, 8'h00, 8'h00, 1'b1);
      end_frame(1'b0, 1'b1);
      @(negedge PCLK_cam);
      checks++;
      if (sb.size() != 0 || done_cnt != 0 || err_cnt != 1) begin
         errors++;
         $display("FAIL backpressure: got pending=%0d done=%0d err=%0d, expected 0 0 1", sb.size(), done_cnt, err_cnt);
      end
      checks++;
      if (drop_count !== 16'(STATS ? 2 : 0) || frame_count !== 8'd0) begin
         errors++;
         $display("FAIL backpressure_stats: got drops=%0d frames=%0d, expected %0d 0",
                  drop_count, frame_count, STATS ? 2 : 0);
      end
   endtask

   task automatic test_short_line();
      do_reset();
      arm();
      begin_frame();
      drive_line(0, H, 8'h00, 8'h00, 1'b1);
      drive_line(1, H - 1, 8'h00, 8'h00, 1'b1);
      drive_line(2, H, 8'h00, 8'h00, 1'b1);
      end_frame(1'b0, 1'b1);
      @(negedge PCLK_cam);
      checks++;
      if (sb.size() != 0 || done_cnt != 0 || err_cnt != 1 || frame_count !== 8'd0) begin
         errors++;
         $display("FAIL short_line: got pending=%0d done=%0d err=%0d frames=%0d, expected 0 0 1 0",
                  sb.size(), done_cnt, err_cnt, frame_count);
      end
   endtask

   task automatic test_mid_frame_arm();
      do_reset();
      tick(); VSYNC_cam = 1'b0;
      tick();
      arm();
      for (int l = 0; l < V; l++) drive_line(l, H, 8'h00, 8'h00, 1'b0);
      tick(); VSYNC_cam = 1'b1;
      repeat (4) tick();
      @(negedge PCLK_cam);
      checks++;
      if (busy !== 1'b1 || done_cnt != 0 || err_cnt != 0) begin
         errors++;
         $display("FAIL mid_arm_wait: got busy=%b done=%0d err=%0d, expected 1 0 0", busy, done_cnt, err_cnt);
      end
      begin_frame();
      full_frame();
      end_frame(1'b1, 1'b0);
      @(negedge PCLK_cam);
      checks++;
      if (sb.size() != 0 || done_cnt != 1 || err_cnt != 0 || frame_count !== 8'(STATS ? 1 : 0)) begin
         errors++;
         $display("FAIL mid_arm: got pending=%0d done=%0d err=%0d frames=%0d, expected 0 1 0 %0d",
                  sb.size(), done_cnt, err_cnt, frame_count, STATS ? 1 : 0);
      end
   endtask

   task automatic test_abort();
      do_reset();
      arm();
      begin_frame();
      drive_line(0, H, 8'h00, 8'h00, 1'b1);
      tick(); HREF_cam = 1'b1; pix_valid = 1'b1; pix_data = 8'h11; wr_ready = 1'b1;
      tick(); pix_data = 8'h12; wr_ready = 1'b0; abort = 1'b1;
      @(negedge PCLK_cam);
      checks++;
      if (wr_valid !== 1'b1 || wr_addr !== AW'(4) || wr_data !== 8'h11) begin
         errors++;
         $display("FAIL abort_pre: got valid=%b addr=%0d data=%02h, expected 1 4 11", wr_valid, wr_addr, wr_data);
      end
      tick(); abort = 1'b0; HREF_cam = 1'b0; pix_valid = 1'b0;
      @(negedge PCLK_cam);
      checks++;
      if (wr_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort: got valid=%b busy=%b, expected 0 0", wr_valid, busy);
      end
      repeat (2) tick();
      wr_ready = 1'b1;
      tick(); VSYNC_cam = 1'b1;
      repeat (5) tick();
      @(negedge PCLK_cam);
      checks++;
      if (sb.size() != 0 || done_cnt != 0 || err_cnt != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_after: got pending=%0d done=%0d err=%0d busy=%b, expected 0 0 0 0",
                  sb.size(), done_cnt, err_cnt, busy);
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_single_shot();
      test_continuous();
      test_backpressure();
      test_short_line();
      test_mid_frame_arm();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cam_capture_ctrl.md
# cam_capture_ctrl

Frame-capture sequencer for the camera path, clocked by the camera pixel clock. It arms on request and aligns to the VSYNC frame boundary. It then accepts assembled greyscale pixels from the byte-assembly stage and issues linear-address writes to the frame buffer over a valid/ready handshake. At the end of each frame it checks frame geometry and reports completion or error, in single-shot or continuous mode.

## Interface
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W ≥ H_ACTIVE*V_ACTIVE
- PCLK_cam  in  1  camera pixel clock; all logic on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse that arms a capture; ignored unless IDLE
- continuous  in  1  sampled at frame end: 1 = re-arm automatically
- abort  in  1  one-cycle pulse: return to IDLE
- VSYNC_cam  in  1  frame sync, high between frames
- HREF_cam  in  1  line valid
- pix_valid  in  1  one pixel available this cycle
- pix_data  in  8  greyscale pixel
- wr_valid  out  1  write request
- wr_ready  in  1  frame buffer accepts write
- wr_addr  out  ADDR_W  linear pixel address
- wr_data  out  8  pixel value
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse, good frame
- frame_err  out  1  one-cycle pulse, bad frame
- frame_count  out  8  completed good frames, wraps at 255→0 (macro-gated)
- drop_count  out  16  dropped pixels, saturates at 0xFFFF (macro-gated)

## Operation
- States: IDLE, ARM, SYNC, CAPTURE.
- IDLE: start → ARM.
- ARM: wait for VSYNC_cam high, then → SYNC. Never begins capture mid-frame.
- SYNC: VSYNC_cam low → CAPTURE. Clears pixel, line and address counters, plus sticky error flags.
- CAPTURE, pixel accept: a pixel is accepted when pix_valid && HREF_cam.
- CAPTURE, line index: a HREF falling edge ends a line. If the pixel count ≠ H_ACTIVE, set sticky geom_err. Increment the line counter and reset the pixel counter.
- CAPTURE, overflow drops: a pixel with pixel index ≥ H_ACTIVE, or with line ≥ V_ACTIVE, is dropped. It sets geom_err and increments drop_count.
- CAPTURE, frame end: a VSYNC rising edge ends the frame.
  - frame_done pulses if line == V_ACTIVE and neither geom_err nor ovr_err is set; otherwise frame_err pulses.
  - Next state is SYNC if continuous, else IDLE. frame_count increments only on frame_done.
- Write path: one output register.
  - wr_addr = line*H_ACTIVE + pixel, kept as an incrementing counter with no multiplier.
  - If an accepted pixel arrives while wr_valid && !wr_ready, the pixel is dropped. It sets sticky ovr_err and increments drop_count; the held write is unchanged.
- abort has priority over all other events. The next state is IDLE and wr_valid clears, even without wr_ready. No done or err pulse is issued.
- start while not IDLE: ignored. start and abort in the same cycle: abort wins.

## Timing
- Reset values: state IDLE, all counters 0, every output 0.
- Edge detect: VSYNC/HREF are registered once and compared with the previous sample, so edges are seen 1 cycle after the pin changes.
- Write latency: accepted pixel at cycle N → wr_valid/wr_addr/wr_data valid at N+1. They are held stable until wr_ready. On the handshake cycle, a new pixel may load the register (back-to-back throughput 1/cycle).
- frame_done/frame_err: asserted in the cycle after the registered VSYNC rising edge. A write still pending at that point completes normally afterwards.
- Counter widths: pixel counter ⌈log2(H_ACTIVE+1)⌉, line counter ⌈log2(V_ACTIVE+1)⌉; both saturate rather than wrap.

## Configuration
- CAM_CTRL_STATS_EN defined: frame_count and drop_count are implemented as above.
- CAM_CTRL_STATS_EN undefined: both ports are tied to 0 and the counters are not built. All other behaviour is identical, including the done/err pulses.

## Structure
- Package cam_pkg: state enum, default H_ACTIVE/V_ACTIVE/ADDR_W constants, pixel and address typedefs.
- Sub-module cam_sync_edge: registers VSYNC/HREF and outputs rise/fall pulses. Instantiated once per signal.

## Test plan
Unless stated otherwise, all scenarios use H_ACTIVE=4, V_ACTIVE=3.
- Clean single shot: start, then 3 lines of 4 pixels with wr_ready=1 → writes at addresses 0..11, one frame_done pulse, return to IDLE, frame_count=1.
- Continuous: continuous=1 over 2 frames → addresses 0..11 twice, two frame_done pulses, busy stays 1, frame_count=2.
- Backpressure: wr_ready=0 for 3 cycles during a line → first pixel held, next 2 pixels dropped, drop_count=2, frame_err at frame end.
- Short line: line 1 has 3 pixels → frame_err, no frame_done, frame_count unchanged.
- Mid-frame arm: start asserted while VSYNC low mid-frame → no writes until the next VSYNC high→low, then a clean frame_done.
- Abort: abort at pixel 5 with wr_valid=1, wr_ready=0 → next cycle IDLE, wr_valid=0, busy=0, no done or err pulse.
